// File: rtl/hazard_ctl_pkg.sv
// Shared opcode constants, FSM encodings, control bundle and helpers for the
// hazard/stall controller.
package hazard_ctl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_LSTALL = 2'd1;
    localparam logic [1:0] ST_MWAIT  = 2'd2;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_bubble;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic pipe_en;
    } ctl_t;

    localparam ctl_t CTL_IDLE   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam ctl_t CTL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam ctl_t CTL_FLUSH  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctl_t CTL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctl_t CTL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_ctl_if.sv
// Pipeline-side bundle of the hazard controller: decode/execute fields in,
// register enables, flushes and statistics out.
interface hazard_ctl_if;
    logic [5:0]  IF_ID_op;
    logic [4:0]  IF_ID_rs;
    logic [4:0]  IF_ID_rt;
    logic        ID_EX_mem_read;
    logic [4:0]  ID_EX_rt;
    logic        EX_MEM_branch_taken;
    logic        mem_busy;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        pipe_en;
    logic        mem_error;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;

    modport master (
        output IF_ID_op, IF_ID_rs, IF_ID_rt, ID_EX_mem_read, ID_EX_rt,
               EX_MEM_branch_taken, mem_busy,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               ex_mem_flush, pipe_en, mem_error, stall_cycles, flush_count
    );

    modport slave (
        input  IF_ID_op, IF_ID_rs, IF_ID_rt, ID_EX_mem_read, ID_EX_rt,
               EX_MEM_branch_taken, mem_busy,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               ex_mem_flush, pipe_en, mem_error, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_ctl_detect.sv
// Combinational load-use compare between the IF/ID instruction and the load
// sitting in ID/EX; also shared with the forwarding checks.
module hazard_detect
    import hazard_ctl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       mem_read,
    input  logic [4:0] ld_rt,
    output logic       hit
);
    assign hit = mem_read && (ld_rt != 5'd0) &&
                 ((ld_rt == rs) || ((ld_rt == rt) && uses_rt(op)));
endmodule

// File: rtl/hazard_ctl.sv
// Hazard/stall controller: load-use bubbles, branch flushes, memory freeze
// with timeout, and saturating stall/flush statistics.
module hazard_ctl
    import hazard_ctl_pkg::*;
#(
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctl_if.slave  hz
);
    localparam logic [3:0]  LAT_M1 = 4'(LOAD_LAT - 1);
    localparam logic [15:0] TMO    = 16'(MEM_TIMEOUT);

    logic [1:0]  state, saved_state, eff_state, state_nxt;
    logic [3:0]  cnt, saved_cnt, eff_cnt, cnt_nxt;
    logic [15:0] tcnt, stall_q, flush_q;
    logic        err_q, hit, busy, br, stall_now;
    ctl_t        ctl;

    assign busy = hz.mem_busy;
    assign br   = hz.EX_MEM_branch_taken;

    hazard_detect u_detect (
        .op       (hz.IF_ID_op),
        .rs       (hz.IF_ID_rs),
        .rt       (hz.IF_ID_rt),
        .mem_read (hz.ID_EX_mem_read),
        .ld_rt    (hz.ID_EX_rt),
        .hit      (hit)
    );

    // While frozen, the pre-freeze state/count drive decisions once memory frees up.
    assign eff_state = (state == ST_MWAIT) ? saved_state : state;
    assign eff_cnt   = (state == ST_MWAIT) ? saved_cnt   : cnt;
    assign stall_now = (eff_state == ST_LSTALL) || ((eff_state == ST_RUN) && hit);

    always_comb begin
        ctl = CTL_IDLE;
        if (rst)            ctl = CTL_RESET;
        else if (busy)      ctl = CTL_FREEZE;
        else if (br)        ctl = CTL_FLUSH;
        else if (stall_now) ctl = CTL_STALL;
    end

    always_comb begin
        state_nxt = eff_state;
        cnt_nxt   = eff_cnt;
        if (busy) begin
            state_nxt = ST_MWAIT;
            cnt_nxt   = cnt;
        end else if (br) begin
            state_nxt = ST_RUN;
            cnt_nxt   = 4'd0;
        end else if (eff_state == ST_LSTALL) begin
            if (eff_cnt <= 4'd1) begin
                state_nxt = ST_RUN;
                cnt_nxt   = 4'd0;
            end else begin
                cnt_nxt   = eff_cnt - 4'd1;
            end
        end else if (hit && (LOAD_LAT > 1)) begin
            state_nxt = ST_LSTALL;
            cnt_nxt   = LAT_M1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            cnt         <= 4'd0;
            saved_state <= ST_RUN;
            saved_cnt   <= 4'd0;
            tcnt        <= 16'd0;
            err_q       <= 1'b0;
            stall_q     <= 16'd0;
            flush_q     <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (busy && (state != ST_MWAIT)) begin
                saved_state <= state;
                saved_cnt   <= cnt;
            end
            tcnt <= busy ? sat_inc(tcnt) : 16'd0;
            if (busy && (sat_inc(tcnt) >= TMO)) err_q <= 1'b1;
            if (!ctl.pc_write) stall_q <= sat_inc(stall_q);
            if (!busy && br)   flush_q <= sat_inc(flush_q);
        end
    end

    assign hz.pc_write     = ctl.pc_write;
    assign hz.if_id_write  = ctl.if_id_write;
    assign hz.id_ex_bubble = ctl.id_ex_bubble;
    assign hz.if_id_flush  = ctl.if_id_flush;
    assign hz.id_ex_flush  = ctl.id_ex_flush;
    assign hz.ex_mem_flush = ctl.ex_mem_flush;
    assign hz.pipe_en      = ctl.pipe_en;
    assign hz.mem_error    = err_q;
    assign hz.stall_cycles = stall_q;
    assign hz.flush_count  = flush_q;
endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard bench for hazard_ctl: one instance at LOAD_LAT=1 and one at
// LOAD_LAT=3/MEM_TIMEOUT=3, driven per scenario from a single sequence.
module tb_hazard_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctl_if h1();
    hazard_ctl_if h3();

    hazard_ctl #(.LOAD_LAT(1), .MEM_TIMEOUT(255)) dut1 (.clk(clk), .rst(rst), .hz(h1));
    hazard_ctl #(.LOAD_LAT(3), .MEM_TIMEOUT(3))   dut3 (.clk(clk), .rst(rst), .hz(h3));

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr;
        logic [4:0] lrt;
        logic       br;
        logic       busy;
    } stim_t;

    // {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, pipe_en, mem_error}
    localparam logic [7:0] IDLE   = 8'b1100_0010;
    localparam logic [7:0] IDLEE  = 8'b1100_0011;
    localparam logic [7:0] STALL  = 8'b0010_0010;
    localparam logic [7:0] STALLE = 8'b0010_0011;
    localparam logic [7:0] FLUSH  = 8'b1101_1110;
    localparam logic [7:0] FRZ    = 8'b0000_0000;
    localparam logic [7:0] FRZE   = 8'b0000_0001;
    localparam logic [7:0] RSTV   = 8'b0011_1100;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    function automatic stim_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic mr, input logic [4:0] lrt, input logic br, input logic busy);
        stim_t s;
        s.op = op; s.rs = rs; s.rt = rt; s.mr = mr; s.lrt = lrt; s.br = br; s.busy = busy;
        return s;
    endfunction

    localparam stim_t IDL = '0;

    task automatic drive1(input stim_t s);
        h1.IF_ID_op = s.op; h1.IF_ID_rs = s.rs; h1.IF_ID_rt = s.rt;
        h1.ID_EX_mem_read = s.mr; h1.ID_EX_rt = s.lrt;
        h1.EX_MEM_branch_taken = s.br; h1.mem_busy = s.busy;
    endtask

    task automatic drive3(input stim_t s);
        h3.IF_ID_op = s.op; h3.IF_ID_rs = s.rs; h3.IF_ID_rt = s.rt;
        h3.ID_EX_mem_read = s.mr; h3.ID_EX_rt = s.lrt;
        h3.EX_MEM_branch_taken = s.br; h3.mem_busy = s.busy;
    endtask

    function automatic logic [7:0] obs1();
        return {h1.pc_write, h1.if_id_write, h1.id_ex_bubble, h1.if_id_flush,
                h1.id_ex_flush, h1.ex_mem_flush, h1.pipe_en, h1.mem_error};
    endfunction

    function automatic logic [7:0] obs3();
        return {h3.pc_write, h3.if_id_write, h3.id_ex_bubble, h3.if_id_flush,
                h3.id_ex_flush, h3.ex_mem_flush, h3.pipe_en, h3.mem_error};
    endfunction

    task automatic test_reset();
        logic [39:0] got;
        drive1(IDL); drive3(IDL);
        #2;
        checks++;
        got = {obs1(), h1.stall_cycles, h1.flush_count};
        if (got !== {RSTV, 32'd0}) begin
            failures++; $display("FAIL reset_dut1 got=%h exp=%h", got, {RSTV, 32'd0});
        end
        repeat (2) @(posedge clk);
        #2;
        checks++;
        got = {obs3(), h3.stall_cycles, h3.flush_count};
        if (got !== {RSTV, 32'd0}) begin
            failures++; $display("FAIL reset_dut3 got=%h exp=%h", got, {RSTV, 32'd0});
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(IDLE);
        #2;
        checks++;
        if (obs1() !== exp_q[0]) begin
            failures++; $display("FAIL reset_release got=%b exp=%b", obs1(), exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_load_use();
        stim_t s[2]; logic [7:0] e[2]; logic [7:0] got, exp;
        s[0] = mk(6'h00, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0); e[0] = STALL;
        s[1] = IDL;                                         e[1] = IDLE;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive1(s[i]); exp_q.push_back(e[i]); #2;
            got = obs1(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL load_use cyc%0d got=%b exp=%b", i, got, exp);
            end
        end
        @(negedge clk); #2; checks++;
        if (h1.stall_cycles !== 16'd1) begin
            failures++; $display("FAIL load_use_stall_cycles got=%0d exp=1", h1.stall_cycles);
        end
    endtask

    task automatic test_no_false_hit();
        stim_t s[4]; logic [7:0] e[4]; logic [7:0] got, exp;
        s[0] = mk(6'h00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0); e[0] = IDLE;
        s[1] = mk(6'h08, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0); e[1] = IDLE;
        s[2] = mk(6'h2B, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0); e[2] = STALL;
        s[3] = IDL;                                         e[3] = IDLE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive1(s[i]); exp_q.push_back(e[i]); #2;
            got = obs1(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL no_false_hit cyc%0d got=%b exp=%b", i, got, exp);
            end
        end
        @(negedge clk); #2; checks++;
        if (h1.stall_cycles !== 16'd2) begin
            failures++; $display("FAIL no_false_hit_stall_cycles got=%0d exp=2", h1.stall_cycles);
        end
    endtask

    task automatic test_branch_wins();
        stim_t s[2]; logic [7:0] e[2]; logic [7:0] got, exp;
        s[0] = mk(6'h00, 5'd8, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0); e[0] = FLUSH;
        s[1] = IDL;                                         e[1] = IDLE;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive1(s[i]); exp_q.push_back(e[i]); #2;
            got = obs1(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL branch_wins cyc%0d got=%b exp=%b", i, got, exp);
            end
        end
        @(negedge clk); #2; checks++;
        if ({h1.flush_count, h1.stall_cycles} !== {16'd1, 16'd2}) begin
            failures++; $display("FAIL branch_wins_counters got=%0d/%0d exp=1/2",
                                 h1.flush_count, h1.stall_cycles);
        end
    endtask

    task automatic test_lat3_stall();
        stim_t s[4]; logic [7:0] e[4]; logic [7:0] got, exp;
        s[0] = mk(6'h04, 5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0); e[0] = STALL;
        s[1] = IDL; e[1] = STALL;
        s[2] = IDL; e[2] = STALL;
        s[3] = IDL; e[3] = IDLE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive3(s[i]); exp_q.push_back(e[i]); #2;
            got = obs3(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL lat3_stall cyc%0d got=%b exp=%b", i, got, exp);
            end
        end
        @(negedge clk); #2; checks++;
        if (h3.stall_cycles !== 16'd3) begin
            failures++; $display("FAIL lat3_stall_cycles got=%0d exp=3", h3.stall_cycles);
        end
    endtask

    task automatic test_lat3_branch();
        stim_t s[4]; logic [7:0] e[4]; logic [7:0] got, exp;
        s[0] = mk(6'h00, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0); e[0] = STALL;
        s[1] = mk(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0); e[1] = FLUSH;
        s[2] = IDL; e[2] = IDLE;
        s[3] = IDL; e[3] = IDLE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive3(s[i]); exp_q.push_back(e[i]); #2;
            got = obs3(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL lat3_branch cyc%0d got=%b exp=%b", i, got, exp);
            end
        end
        checks++;
        if ({h3.flush_count, h3.stall_cycles} !== {16'd1, 16'd4}) begin
            failures++; $display("FAIL lat3_branch_counters got=%0d/%0d exp=1/4",
                                 h3.flush_count, h3.stall_cycles);
        end
    endtask

    task automatic test_freeze_lstall();
        stim_t s[9]; logic [7:0] e[9]; logic [7:0] got, exp;
        stim_t bz;
        bz = mk(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        s[0] = mk(6'h00, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0); e[0] = STALL;
        s[1] = bz;  e[1] = FRZ;
        s[2] = bz;  e[2] = FRZ;
        s[3] = bz;  e[3] = FRZ;
        s[4] = bz;  e[4] = FRZE;
        s[5] = IDL; e[5] = STALLE;
        s[6] = IDL; e[6] = STALLE;
        s[7] = IDL; e[7] = IDLEE;
        s[8] = IDL; e[8] = IDLEE;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); drive3(s[i]); exp_q.push_back(e[i]); #2;
            got = obs3(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL freeze_lstall cyc%0d got=%b exp=%b", i, got, exp);
            end
        end
        checks++;
        if ({h3.flush_count, h3.stall_cycles} !== {16'd1, 16'd11}) begin
            failures++; $display("FAIL freeze_counters got=%0d/%0d exp=1/11",
                                 h3.flush_count, h3.stall_cycles);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] got, exp;
        @(negedge clk); drive3(mk(6'h00, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0));
        exp_q.push_back(STALLE); #2;
        got = obs3(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL async_pre_stall got=%b exp=%b", got, exp);
        end
        @(negedge clk); drive3(mk(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1));
        exp_q.push_back(FRZE); #2;
        got = obs3(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL async_pre_freeze got=%b exp=%b", got, exp);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({obs3(), h3.stall_cycles, h3.flush_count} !== {RSTV, 32'd0}) begin
            failures++; $display("FAIL async_reset_dut3 got=%b/%0d/%0d exp=%b/0/0",
                                 obs3(), h3.stall_cycles, h3.flush_count, RSTV);
        end
        checks++;
        if ({obs1(), h1.stall_cycles, h1.flush_count} !== {RSTV, 32'd0}) begin
            failures++; $display("FAIL async_reset_dut1 got=%b/%0d/%0d exp=%b/0/0",
                                 obs1(), h1.stall_cycles, h1.flush_count, RSTV);
        end
        @(negedge clk); rst = 1'b0; drive3(IDL);
        exp_q.push_back(IDLE); #2;
        got = obs3(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL async_after_release got=%b exp=%b", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_hit();
        test_branch_wins();
        test_lat3_stall();
        test_lat3_branch();
        test_freeze_lstall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Pipeline hazard and stall controller for the 5-stage MIPS core. It compares the instruction in IF/ID against the load in ID/EX to insert load-use bubbles. It flushes the wrong-path stages on a taken branch resolved in MEM and freezes the whole pipeline while data memory is busy. It drives the write enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps saturating stall and flush statistics.

## Interface
Parameters:
- LOAD_LAT, 1: stall cycles per load-use hazard (1..15).
- MEM_TIMEOUT, 255: consecutive busy cycles before `mem_error` sets (1..65535).

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- IF_ID_op  in  6  opcode `[31:26]` of instruction in IF/ID.
- IF_ID_rs  in  5  `[25:21]` of IF/ID instruction.
- IF_ID_rt  in  5  `[20:16]` of IF/ID instruction.
- ID_EX_mem_read  in  1  MemRead bit of ID/EX M control.
- ID_EX_rt  in  5  destination rt held in ID/EX.
- EX_MEM_branch_taken  in  1  branch resolved taken in MEM (PCSrc).
- mem_busy  in  1  data memory not ready this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- id_ex_bubble  out  1  zero WB/M/EX control fields entering ID/EX.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_flush  out  1  clear ID/EX control.
- ex_mem_flush  out  1  clear EX/MEM control.
- pipe_en  out  1  load enable for ID/EX, EX/MEM, MEM/WB.
- mem_error  out  1  sticky memory timeout flag.
- stall_cycles  out  16  saturating count of cycles with `pc_write=0`.
- flush_count  out  16  saturating count of branch flushes.

## Operation
- States: RUN, LSTALL, MWAIT. The state resets to RUN.
- Load-use hit (`hit`) requires all of the following:
  - `ID_EX_mem_read=1`.
  - `ID_EX_rt != 0`.
  - `ID_EX_rt==IF_ID_rs`, or `ID_EX_rt==IF_ID_rt` with `uses_rt`.
  - `uses_rt` is true for op 0x00 (R-type), 0x04 (beq), 0x05 (bne) and 0x2B (sw).
- Outputs are a combinational function of state and inputs. Priority is mem_busy > branch_taken > hit/LSTALL.
- Freeze (mem_busy=1, any state):
  - `pc_write=0`, `if_id_write=0`, `pipe_en=0`; no flush, no bubble.
  - On entry, state becomes MWAIT and the prior state and stall count are saved.
- Branch (mem_busy=0, branch_taken=1):
  - `pc_write=1`, `if_id_write=1`, `pipe_en=1`.
  - `if_id_flush=id_ex_flush=ex_mem_flush=1`.
  - Any pending LSTALL is aborted; next state is RUN; `flush_count` increments.
- Load stall (RUN with `hit`, or LSTALL):
  - `pc_write=0`, `if_id_write=0`, `id_ex_bubble=1`, `pipe_en=1`.
  - In RUN with `hit` and LOAD_LAT>1: go to LSTALL with `cnt=LOAD_LAT-1`.
  - In LSTALL: `cnt` decrements each cycle; return to RUN after the cycle in which `cnt==1`.
- Idle (RUN, no events): `pc_write=if_id_write=pipe_en=1`, all others 0.
- MWAIT:
  - Outputs are frozen while `mem_busy=1`.
  - A timeout counter increments each busy cycle. When it reaches MEM_TIMEOUT, `mem_error` sets and stays set until rst.
  - The first cycle with `mem_busy=0` uses the saved state and `cnt` and applies the normal priority, so a held branch_taken is serviced then.
- Counters saturate at 0xFFFF and never wrap.

## Timing
- All outputs reflect the current cycle's inputs with zero latency. State and counter updates take effect at the next edge.
- While rst=1, independent of clk:
  - `pc_write=if_id_write=pipe_en=0`.
  - `id_ex_bubble=if_id_flush=id_ex_flush=ex_mem_flush=1`.
  - `mem_error=0`, counters 0, `cnt=0`, state RUN.
- On the first edge after rst deasserts, the block behaves as RUN.
- A load-use hazard costs exactly LOAD_LAT cycles of `pc_write=0`, unless a branch pre-empts it.
- Branch flush is a single cycle, with no follow-on stall.
- Simultaneous `hit` and branch: the branch wins and no bubble is issued.
- rst asserted mid-LSTALL or mid-MWAIT: immediate return to reset values; the saved state is discarded.

## Structure
- Shared header `src/decode/hazard_defs.vh`:
  - opcode constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_LW);
  - state encodings (2-bit).
- Sub-module `hazard_detect`: combinational `hit` compare. It is reused by the forwarding-unit checks.
- `hazard_ctl` holds the FSM, the `cnt` register, the saved state, the timeout counter and the statistics counters.

## Test plan
- Load-use: ID_EX_mem_read=1, ID_EX_rt=8, IF_ID op=0x00 with rs=8 -> exactly 1 cycle of `pc_write=0`/`id_ex_bubble=1`, then idle; `stall_cycles=1`.
- No false hit, two cases, each with no stall:
  - ID_EX_rt=0 with rs=0;
  - lw-dependent addi (op 0x08) on rt only.
- Branch wins: `hit` and `EX_MEM_branch_taken=1` in the same cycle -> all three flushes=1, `pc_write=1`, `id_ex_bubble=0`, `flush_count=1`.
- LOAD_LAT=3: hit at cycle 0 -> stall in cycles 0-2; branch_taken in cycle 1 -> flush in cycle 1, RUN in cycle 2.
- Memory freeze during LSTALL:
  - mem_busy held 4 cycles -> `pipe_en=0` for those cycles, then the remaining stall cycles resume;
  - MEM_TIMEOUT=3 -> `mem_error=1` from cycle 4, held until rst.
- Async reset in MWAIT -> outputs jump to reset values before the next edge; counters read 0.
